// File: rtl/mdu_iter.sv
// Iterative 32-cycle multiply/divide unit with HI/LO result registers.
// Signed operations run on magnitudes, and the signs are applied once at the end.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_e;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam logic [WIDTH-1:0]   ZERO_W  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]   ONES_W  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]   ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W  = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [5:0]         LAST_IT = 6'd31;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + ONE_W;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        return ~v + ONE_2W;
    endfunction

    state_e             state_q, state_d;
    logic [5:0]         cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               divz_q, divz_d;
    logic [WIDTH-1:0]   a_orig_q, a_orig_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               a_neg_s, b_neg_s;
    logic [WIDTH-1:0]   a_mag_s, b_mag_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [2*WIDTH-1:0] mul_next_s;
    logic [WIDTH:0]     div_shift_s, div_diff_s;
    logic [WIDTH-1:0]   div_rem_next_s, div_quo_next_s;
    logic [2*WIDTH-1:0] prod_fix_s;

    assign busy_o = (state_q != S_IDLE);
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

    // Operand magnitudes and one multiply or divide step.
    always_comb begin
        a_neg_s     = ~op_i[0] & a_i[WIDTH-1];
        b_neg_s     = ~op_i[0] & b_i[WIDTH-1];
        a_mag_s     = a_neg_s ? neg_w(a_i) : a_i;
        b_mag_s     = b_neg_s ? neg_w(b_i) : b_i;
        // {P, multiplier} shifts right; the carry out of P + M becomes the new top bit.
        mul_sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                    + (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
        mul_next_s  = {mul_sum_s, acc_q[WIDTH-1:1]};
        div_shift_s = {rem_q, acc_q[WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, opb_q};
        div_rem_next_s = div_diff_s[WIDTH] ? div_shift_s[WIDTH-1:0] : div_diff_s[WIDTH-1:0];
        div_quo_next_s = {acc_q[WIDTH-2:0], ~div_diff_s[WIDTH]};
        prod_fix_s  = neg_res_q ? neg_2w(acc_q) : acc_q;
    end

    // Next-state, datapath and HI/LO update.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        divz_d    = divz_q;
        a_orig_d  = a_orig_q;
        opb_d     = opb_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    case (op_i)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            acc_d     = {ZERO_W, a_mag_s};
                            opb_d     = b_mag_s;
                            rem_d     = ZERO_W;
                            cnt_d     = 6'd0;
                            is_div_d  = op_i[1];
                            neg_res_d = a_neg_s ^ b_neg_s;
                            neg_rem_d = a_neg_s;
                            divz_d    = (b_i == ZERO_W);
                            a_orig_d  = a_i;
                            state_d   = S_RUN;
                        end
                        OP_MTHI: hi_d = a_i;
                        OP_MTLO: lo_d = a_i;
                        default: begin
                        end
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + 6'd1;
                if (is_div_q) begin
                    rem_d = div_rem_next_s;
                    acc_d = {acc_q[2*WIDTH-1:WIDTH], div_quo_next_s};
                end else begin
                    acc_d = mul_next_s;
                end
                if (cnt_q == LAST_IT) begin
                    state_d = S_FIN;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_FIN: begin
                if (is_div_q) begin
                    // Divide by zero reports the untouched dividend and an all-ones quotient.
                    if (divz_q) begin
                        hi_d = a_orig_q;
                        lo_d = ONES_W;
                    end else begin
                        hi_d = neg_rem_q ? neg_w(rem_q) : rem_q;
                        lo_d = neg_res_q ? neg_w(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
                    end
                end else begin
                    hi_d = prod_fix_s[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix_s[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= 6'd0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            divz_q    <= 1'b0;
            a_orig_q  <= ZERO_W;
            opb_q     <= ZERO_W;
            acc_q     <= {ZERO_W, ZERO_W};
            rem_q     <= ZERO_W;
            hi_q      <= ZERO_W;
            lo_q      <= ZERO_W;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            divz_q    <= divz_d;
            a_orig_q  <= a_orig_d;
            opb_q     <= opb_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

endmodule
